accum8_seq: RTL and testbench

Sequential multi-operand accumulator that sits directly downstream of the team's 8-bit ripple-carry adder stage. It repeatedly feeds its running sum and the next operand through an 8-bit add with carry-out. It also counts carry-outs, so a list of N operands is summed to a WIDTH+CNT_W-bit result. Operands arrive and the result leaves over valid/ready handshakes.

---
 rtl/accum8_seq.sv | 74 +++++++
 tb/tb_accum8_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/accum8_seq.sv
// accum8_seq: multi-operand accumulator with carry count; define ACCUM8_SAT_EN for saturating mode with sat flag
module accum8_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_ops,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH+CNT_W-1:0] sum_out,
  output logic                   busy
`ifdef ACCUM8_SAT_EN
  ,
  output logic                   sat
`endif
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_acc, w_s;
  logic [CNT_W-1:0] r_carry, r_rem;
  logic w_cout, w_acc_en, w_clr;
`ifdef ACCUM8_SAT_EN
  logic r_sat;
  assign sat = r_sat;
`endif
  assign {w_cout, w_s} = {1'b0, r_acc} + {1'b0, in_data};
  assign in_ready  = r_state == ACCUM;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign sum_out   = {r_carry, r_acc};
  assign w_acc_en  = in_valid && in_ready;
  assign w_clr     = r_state == IDLE && start;
  always_comb begin
    w_next = r_state;
    if (w_clr) w_next = (num_ops == '0) ? DONE : ACCUM;
    else if (w_acc_en && r_rem == CNT_W'(1)) w_next = DONE;
    else if (out_valid && out_ready) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_carry <= '0;
      r_rem   <= '0;
`ifdef ACCUM8_SAT_EN
      r_sat   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_clr) begin
        r_acc   <= '0;
        r_carry <= '0;
        r_rem   <= num_ops;
`ifdef ACCUM8_SAT_EN
        r_sat   <= 1'b0;
`endif
      end else if (w_acc_en) begin
        r_rem <= r_rem - 1'b1;
`ifdef ACCUM8_SAT_EN
        r_acc <= w_cout ? '1 : w_s;
        r_sat <= r_sat | w_cout;
`else
        r_acc   <= w_s;
        r_carry <= (&r_carry) ? r_carry : r_carry + CNT_W'(w_cout);
`endif
      end
    end
  end
endmodule

// File: tb/tb_accum8_seq.sv
// tb_accum8_seq: table-driven and randomized checks of accum8_seq against a plain-arithmetic sum model
module tb_accum8_seq;
  localparam int W = 8, C = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [C-1:0] num_ops = '0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, busy;
  logic [W+C-1:0] sum_out;
`ifdef ACCUM8_SAT_EN
  logic sat;
`endif
  int n_cmp = 0, n_err = 0;
  typedef struct {
    int               n;
    logic [15:0][7:0] ops;
    logic [31:0]      vpat;
    int               hold;
    bit               poke;
    int               exp_w;
    int               exp_s;
  } vec_t;
  vec_t tv[6];

  always #5 clk = ~clk;

  accum8_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ops(num_ops),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out), .busy(busy)
`ifdef ACCUM8_SAT_EN
    , .sat(sat)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0][7:0] mk4(input logic [7:0] a, b, c, d);
    mk4 = '0;
    mk4[0] = a;
    mk4[1] = b;
    mk4[2] = c;
    mk4[3] = d;
  endfunction

  task automatic run(input string nm, input int n, input logic [15:0][7:0] ops,
                     input logic [31:0] vpat, input bit rnd, input int hold,
                     input bit poke, input int exp_w, input int exp_s);
    int k, cyc, e;
    bit acc_now;
`ifdef ACCUM8_SAT_EN
    e = exp_s;
`else
    e = exp_w;
`endif
    @(negedge clk);
    start = 1'b1;
    num_ops = C'(n);
    @(negedge clk);
    start = poke;
    num_ops = 4'd7;
    k = 0;
    cyc = 0;
    while (k < n && cyc < 100) begin
      chk({nm, "/ov_low"}, out_valid, 0);
      in_valid = rnd ? 1'($urandom_range(0, 1)) : vpat[cyc % 32];
      in_data = ops[k];
      acc_now = in_valid && in_ready;
      @(negedge clk);
      if (acc_now) k++;
      cyc++;
    end
    in_valid = 1'b0;
    if (k < n) chk({nm, "/timeout"}, k, n);
    if (!rnd && &vpat) chk({nm, "/latency"}, cyc, n);
    for (int i = 0; i <= hold; i++) begin
      chk({nm, "/out_valid"}, out_valid, 1);
      chk({nm, "/sum"}, sum_out, e);
      chk({nm, "/in_ready"}, in_ready, 0);
      chk({nm, "/busy"}, busy, 1);
`ifdef ACCUM8_SAT_EN
      chk({nm, "/sat"}, sat, exp_w > 255 ? 1 : 0);
`endif
      if (i < hold) @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "/idle_ov"}, out_valid, 0);
    chk({nm, "/idle_busy"}, busy, 0);
    chk({nm, "/idle_sum"}, sum_out, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0][7:0] ops;
    int n, tot;
    tv[0] = '{3, mk4(8'h10, 8'h20, 8'h30, 8'h00), 32'hFFFF_FFFF, 0, 1'b0, 32'h060, 32'h060};
    tv[1] = '{4, mk4(8'hFF, 8'hFF, 8'hFF, 8'hFF), 32'hFFFF_FFFF, 0, 1'b0, 32'h3FC, 32'h0FF};
    tv[2] = '{3, mk4(8'h01, 8'h02, 8'h03, 8'h00), 32'hFFFF_FFF9, 4, 1'b0, 6, 6};
    tv[3] = '{0, mk4(8'h00, 8'h00, 8'h00, 8'h00), 32'hFFFF_FFFF, 1, 1'b0, 0, 0};
    tv[4] = '{2, mk4(8'h05, 8'h06, 8'h00, 8'h00), 32'hFFFF_FFFF, 2, 1'b1, 32'h00B, 32'h00B};
    tv[5] = '{2, mk4(8'h80, 8'h80, 8'h00, 8'h00), 32'hFFFF_FFFF, 0, 1'b0, 32'h100, 32'h0FF};
    repeat (2) @(negedge clk);
    chk("reset/sum", sum_out, 0);
    chk("reset/busy", busy, 0);
    chk("reset/in_ready", in_ready, 0);
    chk("reset/out_valid", out_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      run($sformatf("vec%0d", i), tv[i].n, tv[i].ops, tv[i].vpat, 1'b0,
          tv[i].hold, tv[i].poke, tv[i].exp_w, tv[i].exp_s);
    @(negedge clk);
    start = 1'b1;
    num_ops = 4'd4;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h11;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("midrun/busy", busy, 1);
    chk("midrun/partial", sum_out, 32'h022);
    #2 rst_n = 1'b0;
    #1;
    chk("abort/sum", sum_out, 0);
    chk("abort/busy", busy, 0);
    chk("abort/in_ready", in_ready, 0);
    chk("abort/out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run("rerun", 2, mk4(8'd3, 8'd4, 8'd0, 8'd0), 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 7, 7);
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 15);
      ops = '0;
      tot = 0;
      for (int j = 0; j < n; j++) begin
        ops[j] = 8'($urandom_range(0, 255));
        tot += int'(ops[j]);
      end
      run($sformatf("rnd%0d", r), n, ops, 32'h0, 1'b1, $urandom_range(0, 3),
          1'($urandom_range(0, 1)), tot, tot > 255 ? 255 : tot);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
